// File: rtl/sram_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sfb_pkg
// Description : State encoding, SRAM sizing and display geometry shared by
//               the frame writer and the VGA display stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sfb_pkg;

  localparam int SRAM_ADDR_W  = 20;
  localparam int FRAME_1024SQ = 1048576;

  // Display geometry (1280x1024 @ 60 Hz, 108 MHz pixel clock); the stored
  // image is the 1024x1024 window inside the active area.
  localparam int DISP_H_ACTIVE = 1280;
  localparam int DISP_V_ACTIVE = 1024;
  localparam int DISP_H_TOTAL  = 1688;
  localparam int DISP_V_TOTAL  = 1066;
  localparam int IMG_W         = 1024;
  localparam int IMG_H         = 1024;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_SETUP    = 3'd2,
    S_STROBE   = 3'd3,
    S_HOLD     = 3'd4,
    S_ACCEPT   = 3'd5,
    S_DONE     = 3'd6
  } sfw_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Interface   : sram_frame_writer_if
// Description : Pixel stream (valid/ready + sof) and external SRAM bus.
//               master = frame writer side, slave = stream source / SRAM pad.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_frame_writer_if #(
  parameter int ADDR_W = 20
);
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic [7:0]        pix_r;
  logic [7:0]        pix_b;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_ce_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport master (
    input  pix_valid, pix_sof, pix_r, pix_b,
    output pix_ready, sram_addr, sram_dq_out, sram_dq_oe,
    output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  modport slave (
    output pix_valid, pix_sof, pix_r, pix_b,
    input  pix_ready, sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );
endinterface
`default_nettype wire

// File: rtl/sram_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : sram_frame_writer
// Description : Captures one frame of {R,B} pixels into external 16-bit SRAM
//               with a SETUP/STROBE/HOLD write cycle, holding the display
//               stage off the SRAM for the duration of the write.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_frame_writer
  import sfb_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int FRAME_WORDS = FRAME_1024SQ
) (
  input  logic                 clk108,
  input  logic                 rst,
  input  logic                 start,
  sram_frame_writer_if.master  bus,
  output logic                 disp_en,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  sfw_state_t state;
  logic       xfer;

  // Chip and both byte lanes stay enabled; only we_n/oe_n gate accesses.
  assign bus.sram_ce_n = 1'b0;
  assign bus.sram_ub_n = 1'b0;
  assign bus.sram_lb_n = 1'b0;

  // pix_ready is registered, so a transfer is simply valid & ready.
  assign xfer = bus.pix_valid & bus.pix_ready;

  // Write FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clk108) begin
    if (rst) begin
      state           <= S_IDLE;
      bus.sram_addr   <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe  <= 1'b0;
      bus.sram_we_n   <= 1'b1;
      bus.sram_oe_n   <= 1'b0;
      bus.pix_ready   <= 1'b0;
      disp_en         <= 1'b1;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_WAIT_SOF;
            disp_en       <= 1'b0;
            bus.sram_oe_n <= 1'b1;
            bus.pix_ready <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_WAIT_SOF: begin
          // Pixels before the first sof are consumed and dropped.
          if (xfer && bus.pix_sof) begin
            state           <= S_SETUP;
            bus.sram_dq_out <= {bus.pix_r, bus.pix_b};
            bus.sram_addr   <= '0;
            bus.sram_dq_oe  <= 1'b1;
            bus.pix_ready   <= 1'b0;
          end
        end
        S_SETUP: begin
          state         <= S_STROBE;
          bus.sram_we_n <= 1'b0;
        end
        S_STROBE: begin
          state         <= S_HOLD;
          bus.sram_we_n <= 1'b1;
        end
        S_HOLD: begin
          // Last-address check precedes the increment, so the address never wraps.
          if (bus.sram_addr == LAST_ADDR) begin
            state          <= S_DONE;
            frame_done     <= 1'b1;
            bus.sram_dq_oe <= 1'b0;
          end else begin
            state         <= S_ACCEPT;
            bus.sram_addr <= bus.sram_addr + ADDR_W'(1);
            bus.pix_ready <= 1'b1;
          end
        end
        S_ACCEPT: begin
          // A sof here restarts the frame at address 0.
          if (xfer) begin
            state           <= S_SETUP;
            bus.sram_dq_out <= {bus.pix_r, bus.pix_b};
            bus.pix_ready   <= 1'b0;
            if (bus.pix_sof) begin
              bus.sram_addr <= '0;
            end
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          frame_done    <= 1'b0;
          disp_en       <= 1'b1;
          busy          <= 1'b0;
          bus.sram_oe_n <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_frame_writer
// Description : Directed self-checking bench for sram_frame_writer with a
//               16-word frame and a behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_frame_writer;

  localparam int ADDR_W = 20;
  localparam int FW     = 16;

  logic clk108 = 1'b0;
  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic disp_en, busy, frame_done;

  int total = 0;
  int bad   = 0;

  logic [15:0]       mem [FW];
  int                wr_count = 0;
  int                fd_count = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [15:0]       prev_dq   = '0;
  logic              prev_we   = 1'b1;

  sram_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

  sram_frame_writer #(.ADDR_W(ADDR_W), .FRAME_WORDS(FW)) dut (
    .clk108     (clk108),
    .rst        (rst),
    .start      (start),
    .bus        (bus.master),
    .disp_en    (disp_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk108 = ~clk108;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk108);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] r, input logic [7:0] b, input logic sof, input int gap);
    int n;
    repeat (gap) step();
    bus.pix_valid = 1'b1;
    bus.pix_r     = r;
    bus.pix_b     = b;
    bus.pix_sof   = sof;
    n = 0;
    while (!bus.pix_ready && n < 50) begin
      step();
      n++;
    end
    chk("pix_ready_wait", {31'd0, bus.pix_ready}, 32'd1);
    step();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!frame_done && n < 20) begin
      step();
      n++;
    end
    chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
    chk("disp_en_in_done", {31'd0, disp_en}, 32'd0);
    chk("pix_ready_in_done", {31'd0, bus.pix_ready}, 32'd0);
    step();
    chk("disp_en_after_done", {31'd0, disp_en}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < FW; i++) mem[i] = 16'hDEAD;
    wr_count = 0;
    fd_count = 0;
  endtask

  task automatic check_mem(input logic [7:0] rb, input logic [7:0] bb);
    logic [7:0] er, eb;
    for (int i = 0; i < FW; i++) begin
      er = rb + 8'(i);
      eb = bb + 8'(i);
      chk($sformatf("mem[%0d]", i), {16'd0, mem[i]}, {16'd0, er, eb});
    end
  endtask

  // SRAM model and write-cycle checks, sampled mid-cycle.
  always @(negedge clk108) begin
    if (!rst) begin
      if (bus.sram_we_n === 1'b0) begin
        chk("strobe_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd1);
        chk("strobe_addr_range", {31'd0, (bus.sram_addr < ADDR_W'(FW))}, 32'd1);
        chk("strobe_single_cycle", {31'd0, prev_we}, 32'd1);
        chk("setup_addr_stable", 32'(bus.sram_addr), 32'(prev_addr));
        chk("setup_dq_stable", {16'd0, bus.sram_dq_out}, {16'd0, prev_dq});
        mem[bus.sram_addr[3:0]] = bus.sram_dq_out;
        wr_count++;
      end
      if (prev_we === 1'b0) begin
        chk("hold_addr_stable", 32'(bus.sram_addr), 32'(prev_addr));
        chk("hold_dq_stable", {16'd0, bus.sram_dq_out}, {16'd0, prev_dq});
      end
      if (frame_done === 1'b1) fd_count++;
    end
    prev_addr = bus.sram_addr;
    prev_dq   = bus.sram_dq_out;
    prev_we   = bus.sram_we_n;
  end

  initial begin
    int gap;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_r     = 8'd0;
    bus.pix_b     = 8'd0;
    clear_model();

    // Reset values
    step();
    step();
    rst = 1'b0;
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_dq", {16'd0, bus.sram_dq_out}, 32'd0);
    chk("rst_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
    chk("rst_we_n", {31'd0, bus.sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, bus.sram_oe_n}, 32'd0);
    chk("rst_ties", {29'd0, bus.sram_ce_n, bus.sram_ub_n, bus.sram_lb_n}, 32'd0);
    chk("rst_disp_en", {31'd0, disp_en}, 32'd1);
    chk("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // Full frame, back-to-back pixels
    clear_model();
    pulse_start();
    chk("ws_busy", {31'd0, busy}, 32'd1);
    chk("ws_disp_en", {31'd0, disp_en}, 32'd0);
    chk("ws_oe_n", {31'd0, bus.sram_oe_n}, 32'd1);
    chk("ws_pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    for (int i = 0; i < FW; i++) send_pix(8'(i), 8'hA0 + 8'(i), (i == 0), 0);
    wait_done();
    check_mem(8'h00, 8'hA0);
    chk("t2_writes", 32'(wr_count), 32'd16);
    chk("t2_fd_count", 32'(fd_count), 32'd1);

    // Reset during STROBE
    pulse_start();
    send_pix(8'h11, 8'h22, 1'b1, 0);
    step();
    chk("t1_in_strobe", {31'd0, bus.sram_we_n}, 32'd0);
    rst = 1'b1;
    step();
    chk("t1_we_n", {31'd0, bus.sram_we_n}, 32'd1);
    chk("t1_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
    chk("t1_disp_en", {31'd0, disp_en}, 32'd1);
    chk("t1_addr", 32'(bus.sram_addr), 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Pre-sof pixels are discarded
    clear_model();
    pulse_start();
    send_pix(8'h55, 8'h66, 1'b0, 0);
    send_pix(8'h77, 8'h88, 1'b0, 0);
    chk("t3_no_write", 32'(wr_count), 32'd0);
    chk("t3_still_ready", {31'd0, bus.pix_ready}, 32'd1);
    for (int i = 0; i < FW; i++) send_pix(8'h10 + 8'(i), 8'(i), (i == 0), 0);
    wait_done();
    check_mem(8'h10, 8'h00);
    chk("t3_writes", 32'(wr_count), 32'd16);

    // Random valid gaps
    clear_model();
    pulse_start();
    for (int i = 0; i < FW; i++) begin
      gap = ($urandom_range(0, 99) < 30) ? int'($urandom_range(1, 3)) : 0;
      send_pix(8'(i), 8'hA0 + 8'(i), (i == 0), gap);
    end
    wait_done();
    check_mem(8'h00, 8'hA0);
    chk("t4_writes", 32'(wr_count), 32'd16);

    // Resync: sof again at pixel 5
    clear_model();
    pulse_start();
    for (int i = 0; i < 5; i++) send_pix(8'(i), 8'hA0 + 8'(i), (i == 0), 0);
    for (int k = 0; k < FW; k++) begin
      send_pix(8'h40 + 8'(k), 8'hC0 + 8'(k), (k == 0), 0);
      if (k == 14) begin
        repeat (4) step();
        chk("t5_no_early_done", 32'(fd_count), 32'd0);
      end
    end
    wait_done();
    check_mem(8'h40, 8'hC0);
    chk("t5_writes", 32'(wr_count), 32'd21);
    chk("t5_fd_count", 32'(fd_count), 32'd1);

    // start while busy is ignored
    clear_model();
    pulse_start();
    pulse_start();
    chk("t6_ws_ready", {31'd0, bus.pix_ready}, 32'd1);
    chk("t6_ws_busy", {31'd0, busy}, 32'd1);
    chk("t6_ws_disp_en", {31'd0, disp_en}, 32'd0);
    chk("t6_ws_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
    send_pix(8'h00, 8'hA0, 1'b1, 0);
    repeat (3) step();
    chk("t6_in_accept", {31'd0, bus.pix_ready}, 32'd1);
    pulse_start();
    chk("t6_acc_ready", {31'd0, bus.pix_ready}, 32'd1);
    chk("t6_acc_addr", 32'(bus.sram_addr), 32'd1);
    chk("t6_acc_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i < FW; i++) send_pix(8'(i), 8'hA0 + 8'(i), 1'b0, 0);
    wait_done();
    check_mem(8'h00, 8'hA0);
    chk("t6_writes", 32'(wr_count), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
